// File: rtl/apb_master_ctrl_if.sv
// Request/response and APB bus signals of the APB master sequencer, grouped with
// master (controller) and slave (front end + peripheral side) modports.
interface apb_master_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  Req_valid;
  logic                  Req_ready;
  logic                  Req_write;
  logic [ADDR_WIDTH-1:0] Req_addr;
  logic [DATA_WIDTH-1:0] Req_wdata;
  logic                  Resp_valid;
  logic                  Resp_err;
  logic [DATA_WIDTH-1:0] Resp_rdata;
  logic [2:0]            Pselx;
  logic                  Penable;
  logic                  Pwrite;
  logic [ADDR_WIDTH-1:0] Paddr;
  logic [DATA_WIDTH-1:0] Pwdata;
  logic [DATA_WIDTH-1:0] Prdata;
  logic                  Pready;

  modport master (
    input  Req_valid, Req_write, Req_addr, Req_wdata, Prdata, Pready,
    output Req_ready, Resp_valid, Resp_err, Resp_rdata,
           Pselx, Penable, Pwrite, Paddr, Pwdata
  );

  modport slave (
    output Req_valid, Req_write, Req_addr, Req_wdata, Prdata, Pready,
    input  Req_ready, Resp_valid, Resp_err, Resp_rdata,
           Pselx, Penable, Pwrite, Paddr, Pwdata
  );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB master sequencer: one request at a time, decode, SETUP/ACCESS with wait states.
// Optional ACCESS timeout abort enabled by macro APB_CTRL_TIMEOUT_EN.
module apb_master_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                 Hclk,
  input  logic                 Hreset,
  apb_master_ctrl_if.master    bus
);
  localparam int unsigned SEL_W = 3;
  localparam int unsigned DEC_W = 6;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_ERR} state_e;

  state_e                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [SEL_W-1:0]      psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [SEL_W-1:0]      sel_c;
  logic                  timeout_c;

  // Peripheral decode on the top address bits; zero means decode error
  always_comb begin
    sel_c = '0;
    case (bus.Req_addr[ADDR_WIDTH-1 -: DEC_W])
      6'h20:   sel_c = 3'b001;
      6'h21:   sel_c = 3'b010;
      6'h22:   sel_c = 3'b100;
      default: sel_c = '0;
    endcase
  end

`ifdef APB_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Counts Pready-low ACCESS cycles; cleared while in SETUP so it starts at 0 in ACCESS
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ST_SETUP)
      wait_cnt_d = '0;
    else if (state_q == ST_ACCESS && !bus.Pready)
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end

  assign timeout_c = (wait_cnt_q == CNT_W'(TIMEOUT - 1)) && !bus.Pready;
`else
  localparam int unsigned unused_timeout_p = TIMEOUT;
  assign timeout_c = 1'b0;
`endif

  // Next-state and next-output logic; every output is a register loaded from here
  always_comb begin
    state_d      = state_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    psel_d       = psel_q;
    penable_d    = 1'b0;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        psel_d      = '0;
        if (bus.Req_valid) begin
          req_ready_d = 1'b0;
          if (sel_c != '0) begin
            state_d  = ST_SETUP;
            psel_d   = sel_c;
            pwrite_d = bus.Req_write;
            paddr_d  = bus.Req_addr;
            pwdata_d = bus.Req_wdata;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        penable_d = 1'b1;
        if (bus.Pready) begin
          state_d      = ST_IDLE;
          psel_d       = '0;
          penable_d    = 1'b0;
          resp_valid_d = 1'b1;
          req_ready_d  = 1'b1;
          if (!pwrite_q) resp_rdata_d = bus.Prdata;
        end else if (timeout_c) begin
          state_d      = ST_IDLE;
          psel_d       = '0;
          penable_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          req_ready_d  = 1'b1;
        end
      end
      ST_ERR: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        resp_rdata_d = '0;
        req_ready_d  = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        psel_d      = '0;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      psel_q       <= '0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
    end
  end

  assign bus.Req_ready  = req_ready_q;
  assign bus.Resp_valid = resp_valid_q;
  assign bus.Resp_err   = resp_err_q;
  assign bus.Resp_rdata = resp_rdata_q;
  assign bus.Pselx      = psel_q;
  assign bus.Penable    = penable_q;
  assign bus.Pwrite     = pwrite_q;
  assign bus.Paddr      = paddr_q;
  assign bus.Pwdata     = pwdata_q;
endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- APB master sequencer for the AHB-to-APB bridge; sits between the AHB slave front end and the APB interface stage.
- Accepts one latched transfer request at a time.
- Decodes the target peripheral and runs the APB IDLE -> SETUP -> ACCESS protocol, with Pready wait states.
- Returns read data or an error response to the AHB side.

Parameters:
- ADDR_WIDTH, 32, request/APB address width
- DATA_WIDTH, 32, request/APB data width
- TIMEOUT, 16, max ACCESS cycles before abort (used only with the optional feature)

Ports:
- Hclk  input  1  system clock, all state changes on rising edge
- Hreset  input  1  asynchronous, active-high reset
- Req_valid  input  1  transfer request present
- Req_ready  output  1  controller can accept a request this cycle
- Req_write  input  1  1 = write, 0 = read
- Req_addr  input  ADDR_WIDTH  transfer address
- Req_wdata  input  DATA_WIDTH  write data
- Resp_valid  output  1  one-cycle pulse, transfer finished
- Resp_err  output  1  qualifies Resp_valid; 1 = decode error or timeout
- Resp_rdata  output  DATA_WIDTH  read data, valid with Resp_valid on reads
- Pselx  output  3  one-hot peripheral select
- Penable  output  1  APB enable
- Pwrite  output  1  APB direction
- Paddr  output  ADDR_WIDTH  APB address
- Pwdata  output  DATA_WIDTH  APB write data
- Prdata  input  DATA_WIDTH  APB read data
- Pready  input  1  peripheral ready; extends ACCESS while 0

Behaviour:
- Reset (Hreset=1, asynchronous): state ST_IDLE.
  - All outputs 0 except Req_ready=1.
  - Paddr, Pwdata, Resp_rdata = 0.
  - Reset mid-transfer drops Pselx and Penable immediately; no response is issued.
- All outputs are registered.
- Handshake: request is accepted on a rising edge where Req_valid & Req_ready. Req_ready=1 only in ST_IDLE.
- Address decode on Req_addr[31:26]:
  - 6'h20 -> Pselx 3'b001
  - 6'h21 -> 3'b010
  - 6'h22 -> 3'b100
  - anything else -> decode error
- ST_IDLE:
  - On accept with a valid decode: latch addr, wdata, write and select; go to ST_SETUP.
  - On accept with invalid decode: go to ST_ERR.
  - No request: stay in ST_IDLE.
- ST_SETUP: Pselx=select, Penable=0, Paddr/Pwrite/Pwdata driven. Exactly 1 cycle, then ST_ACCESS.
- ST_ACCESS: Pselx held, Penable=1, all APB outputs stable.
  - Pready=0: stay in ST_ACCESS (wait state).
  - Pready=1 sampled:
    - On reads, capture Prdata into Resp_rdata.
    - Next cycle: Pselx=0, Penable=0, Resp_valid=1, Resp_err=0, state ST_IDLE.
- ST_ERR: next cycle Resp_valid=1, Resp_err=1, Resp_rdata=0, state ST_IDLE. No APB cycle is generated (Pselx stays 0).
- Resp_valid is a single-cycle pulse. Req_ready returns to 1 in the same cycle as Resp_valid, so the minimum repeat is one request per 3 cycles (SETUP, ACCESS, IDLE).
- Resp_rdata holds its last value until the next read completes. Writes leave it unchanged.
- Minimum latency, accept edge to Resp_valid: 3 cycles with zero wait states, plus 1 cycle per wait state.
- Req_* inputs are ignored outside ST_IDLE. Latched values are never updated mid-transfer.

Optional Feature:
- Macro: APB_CTRL_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ST_ACCESS and increments each ACCESS cycle with Pready=0.
  - When the counter reaches TIMEOUT-1 with Pready still 0, the transfer aborts: next cycle Pselx=0, Penable=0, Resp_valid=1, Resp_err=1, Resp_rdata unchanged, state ST_IDLE.
  - Pready=1 on the abort cycle wins: normal completion.
- Not defined: no counter; ACCESS waits indefinitely for Pready.

Test Plan:
- Read, zero wait states: reset; Req addr 32'h8000_0010, write=0, Pready=1, Prdata=32'hA5A5_0001.
  -> Pselx=001 for 2 cycles, Penable high in the 2nd; Resp_valid one cycle later with Resp_rdata=32'hA5A5_0001, Resp_err=0.
- Write, 3 wait states: addr 32'h8400_0004, wdata 32'hDEAD_BEEF, Pready low 3 ACCESS cycles.
  -> Pselx=010, Pwrite=1, Pwdata stable across all 4 ACCESS cycles; Resp_valid 6 cycles after accept.
- Decode error: addr 32'h9000_0000.
  -> Pselx never asserted; Resp_valid=1, Resp_err=1 two cycles after accept.
- Back-to-back: hold Req_valid high across two requests (32'h8800_0000, then 32'h8000_0000).
  -> second accepted in the Resp_valid cycle of the first; Pselx 100, then 001, with no overlap.
- Reset mid-ACCESS: assert Hreset with Pready=0.
  -> Pselx, Penable and Resp_valid go 0 asynchronously; Req_ready=1 after release.
- With APB_CTRL_TIMEOUT_EN, TIMEOUT=16, Pready held 0.
  -> abort after 16 ACCESS cycles with Resp_err=1; without the macro, the controller remains in ACCESS.
